// File: rtl/uart_dc_cmd_router_if.sv
// Host-side UART line, channel-ready inputs and register-write / launch outputs of the DC command router.
interface uart_dc_cmd_router_if #(
  parameter int DAC_CHANNEL = 4,
  parameter int DEPTH       = 2
);
  localparam int AW = $clog2(DEPTH * 3 + 2);

  logic                   rx;
  logic [DAC_CHANNEL-1:0] ch_ready;
  logic [DAC_CHANNEL-1:0] reg_we;
  logic [AW-1:0]          reg_addr;
  logic [31:0]            reg_data;
  logic                   launch;
  logic [DAC_CHANNEL-1:0] launch_mask;
  logic [127:0]           launch_regs;
  logic                   busy;

  modport master (
    output rx, ch_ready,
    input  reg_we, reg_addr, reg_data, launch, launch_mask, launch_regs, busy
  );

  modport slave (
    input  rx, ch_ready,
    output reg_we, reg_addr, reg_data, launch, launch_mask, launch_regs, busy
  );
endinterface

// File: rtl/uart_dc_cmd_router.sv
// 8N1 UART receiver feeding a header-sliding word framer that writes per-channel DC register
// frames and issues a ready-gated, masked launch.
module uart_dc_cmd_router #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 921_600,
  parameter int DAC_CHANNEL = 4,
  parameter int DEPTH       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_dc_cmd_router_if.slave  bus
);
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int CW         = $clog2(CPB + 1);
  localparam int TOTAL_REGS = DEPTH * 3 + 2;
  localparam int AW         = $clog2(TOTAL_REGS);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [AW-1:0] LAST    = AW'(TOTAL_REGS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {HDR, DC_PL, LAUNCH_PL, LAUNCH_WAIT} st_t;

  logic                   rx_s1, rx_s2, rx_d;
  rx_st_t                 rx_st;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             sh;
  logic                   stop_tick, byte_ok, frame_err;

  st_t                    st;
  logic [31:0]            word, new_w;
  logic [1:0]             byte_cnt;
  logic [AW-1:0]          word_cnt;
  logic [DAC_CHANNEL-1:0] ch_oh, hdr_oh, lmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_d    <= 1'b1;
      rx_st   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rx_st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s2) rx_st <= RX_START;
        end
        RX_START: begin
          // a start bit that is high again at mid-bit was a glitch: rearm
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == CPB_M1) begin
            cnt     <= '0;
            sh      <= {rx_s2, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == CPB_M1) begin
            cnt   <= '0;
            rx_st <= RX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // byte events are taken straight off the stop-bit sample so strobes land one cycle later
  assign stop_tick = (rx_st == RX_STOP) && (cnt == CPB_M1);
  assign byte_ok   = stop_tick && rx_s2;
  assign frame_err = stop_tick && !rx_s2;
  assign lmask     = bus.launch_regs[96 +: DAC_CHANNEL];

  always_comb begin
    new_w  = {word[23:0], sh};
    hdr_oh = '0;
    for (int c = 0; c < DAC_CHANNEL; c++)
      hdr_oh[c] = (new_w == ~(32'd1 << (c + 8)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= HDR;
      word            <= '0;
      byte_cnt        <= '0;
      word_cnt        <= '0;
      ch_oh           <= '0;
      bus.reg_we      <= '0;
      bus.reg_addr    <= '0;
      bus.reg_data    <= '0;
      bus.launch      <= 1'b0;
      bus.launch_mask <= '0;
      bus.launch_regs <= '0;
      bus.busy        <= 1'b0;
    end else begin
      bus.reg_we <= '0;
      bus.launch <= 1'b0;
      case (st)
        HDR: if (byte_ok) begin
          word     <= new_w;
          byte_cnt <= '0;
          word_cnt <= '0;
          if (new_w == 32'hFFFF_FFFF) begin
            st       <= LAUNCH_PL;
            bus.busy <= 1'b1;
          end else if (|hdr_oh) begin
            st       <= DC_PL;
            ch_oh    <= hdr_oh;
            bus.busy <= 1'b1;
          end
        end
        DC_PL: begin
          if (frame_err) begin
            st       <= HDR;
            byte_cnt <= '0;
            bus.busy <= 1'b0;
          end else if (byte_ok) begin
            word     <= new_w;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              bus.reg_we   <= ch_oh;
              bus.reg_addr <= word_cnt;
              bus.reg_data <= new_w;
              word_cnt     <= word_cnt + 1'b1;
              if (word_cnt == LAST) begin
                st       <= HDR;
                bus.busy <= 1'b0;
              end
            end
          end
        end
        LAUNCH_PL: begin
          if (frame_err) begin
            st       <= HDR;
            byte_cnt <= '0;
            bus.busy <= 1'b0;
          end else if (byte_ok) begin
            word     <= new_w;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              // shifting in leaves w0 in the top word after the fourth
              bus.launch_regs <= {bus.launch_regs[95:0], new_w};
              word_cnt        <= word_cnt + 1'b1;
              if (word_cnt[1:0] == 2'd3) st <= LAUNCH_WAIT;
            end
          end
        end
        LAUNCH_WAIT: begin
          if ((bus.ch_ready & lmask) == lmask) begin
            bus.launch      <= 1'b1;
            bus.launch_mask <= lmask;
            st              <= HDR;
            bus.busy        <= 1'b0;
          end
        end
        default: st <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_dc_cmd_router.sv
// Directed plus randomized UART byte streams checked against a byte-level protocol model.
module tb_uart_dc_cmd_router;
  localparam int DC    = 4;
  localparam int DEPTH = 2;
  localparam int TOT   = DEPTH * 3 + 2;
  localparam int CPB   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_dc_cmd_router_if #(.DAC_CHANNEL(DC), .DEPTH(DEPTH)) bus ();

  uart_dc_cmd_router #(
    .CLK_FREQ(100_000_000), .BAUD(6_250_000), .DAC_CHANNEL(DC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model: protocol as seen at byte level
  int          m_mode;    // 0 header hunt, 1 dc payload, 2 launch payload, 3 waiting for ready
  logic [31:0] m_win;
  int          m_cnt, m_ch;
  logic [31:0] m_lw [4];
  logic [38:0]  exp_q[$], obs_q[$];
  logic [131:0] exp_l[$], obs_l[$];

  task automatic model_reset();
    m_mode = 0; m_win = '0; m_cnt = 0; m_ch = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ferr);
    if (m_mode == 3) return;
    if (ferr) begin
      if (m_mode != 0) begin m_mode = 0; m_cnt = 0; end
      return;
    end
    m_win = {m_win[23:0], b};
    if (m_mode == 0) begin
      if (m_win == 32'hFFFF_FFFF) begin m_mode = 2; m_cnt = 0; end
      else for (int c = 0; c < DC; c++)
        if (m_win == ~(32'd1 << (c + 8))) begin m_mode = 1; m_ch = c; m_cnt = 0; end
    end else if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt % 4 == 0) exp_q.push_back({4'(1 << m_ch), 3'(m_cnt / 4 - 1), m_win});
      if (m_cnt == 4 * TOT) m_mode = 0;
    end else begin
      m_cnt++;
      if (m_cnt % 4 == 0) m_lw[m_cnt / 4 - 1] = m_win;
      if (m_cnt == 16) m_mode = 3;
    end
  endtask

  task automatic model_wait(input logic [DC-1:0] rdy);
    logic [DC-1:0] mk;
    mk = m_lw[0][DC-1:0];
    if (m_mode == 3 && ((rdy & mk) == mk)) begin
      exp_l.push_back({mk, m_lw[0], m_lw[1], m_lw[2], m_lw[3]});
      m_mode = 0;
    end
  endtask

  always @(negedge clk) begin
    if (bus.reg_we != '0) obs_q.push_back({bus.reg_we, bus.reg_addr, bus.reg_data});
    if (bus.launch) obs_l.push_back({bus.launch_mask, bus.launch_regs});
    if (bus.reg_we != '0 || bus.launch)
      chk("strobe_excl", {126'd0, $onehot0(bus.reg_we), !(bus.launch && bus.reg_we != '0)}, 128'd3);
  end

  task automatic send_byte(input logic [7:0] b, input bit ferr);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = !ferr;
    repeat (CPB) @(negedge clk);
    if (ferr) begin
      bus.rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    model_byte(b, ferr);
    model_wait(bus.ch_ready);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic check_writes(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, 128'(obs_q.pop_front()), 128'(exp_q.pop_front()));
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic check_launch(input string tag);
    logic [131:0] o, e;
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(obs_l.size()), 128'(exp_l.size()));
    while (obs_l.size() > 0 && exp_l.size() > 0) begin
      o = obs_l.pop_front(); e = exp_l.pop_front();
      chk({tag, "_mask"}, 128'(o[131:128]), 128'(e[131:128]));
      chk({tag, "_regs"}, o[127:0], e[127:0]);
    end
    obs_l.delete(); exp_l.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_we"},    128'(bus.reg_we), 128'd0);
    chk({tag, "_addr"},  128'(bus.reg_addr), 128'd0);
    chk({tag, "_data"},  128'(bus.reg_data), 128'd0);
    chk({tag, "_launch"},128'(bus.launch), 128'd0);
    chk({tag, "_lmask"}, 128'(bus.launch_mask), 128'd0);
    chk({tag, "_lregs"}, bus.launch_regs, 128'd0);
    chk({tag, "_busy"},  128'(bus.busy), 128'd0);
  endtask

  task automatic check_busy(input string tag);
    @(negedge clk);
    chk(tag, 128'(bus.busy), 128'(m_mode != 0));
  endtask

  int kind, ns, ch, k, kb;

  initial begin
    bus.rx = 1'b1;
    bus.ch_ready = '0;
    model_reset();
    repeat (5) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset in the middle of a frame, then a clean channel-0 frame
    send_word(32'hFFFF_FEFF);
    send_word(32'hA5A5_0001);
    bus.rx = 1'b0;
    repeat (CPB * 2 + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    check_idle("midreset");
    rst_n = 1'b1;
    model_reset();
    repeat (3 * CPB) @(negedge clk);
    check_writes("prereset_wr");

    send_word(32'hFFFF_FEFF);
    for (int i = 1; i <= TOT; i++) send_word(32'(i));
    check_writes("ch0_frame");
    check_busy("ch0_busy");

    send_word(32'hFFFF_FDFF);
    for (int i = 0; i < TOT; i++) send_word($urandom);
    check_writes("ch1_frame");

    send_word(32'hFFFF_FF7F);
    check_writes("bad_hdr");
    check_busy("bad_hdr_busy");

    send_byte(8'h55, 1'b0);
    send_word(32'hFFFF_FBFF);
    for (int i = 0; i < TOT; i++) send_word($urandom);
    check_writes("resync_ch2");

    // launch held off until ready[2] joins ready[0]
    send_word(32'h0000_0000);
    @(negedge clk); bus.ch_ready = 4'b0001;
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0005);
    send_word(32'h0); send_word(32'h0); send_word(32'h0);
    check_launch("launch_held");
    check_busy("launch_wait_busy");
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    @(negedge clk); bus.ch_ready = 4'b0101;
    model_wait(bus.ch_ready);
    check_launch("launch_go");
    chk("launch_mask_hold", 128'(bus.launch_mask), 128'h5);
    send_byte(8'hFF, 1'b0);
    check_busy("dropped_bytes_busy");

    // zero mask fires without any ready
    @(negedge clk); bus.ch_ready = '0;
    send_byte(8'h00, 1'b0);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0000);
    send_word($urandom); send_word($urandom); send_word($urandom);
    check_launch("launch_zero");
    chk("launch_mask_zero", 128'(bus.launch_mask), 128'h0);

    // framing error on the last byte of word 3
    send_word(32'hFFFF_FEFF);
    for (int i = 0; i < 3; i++) send_word($urandom);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    check_writes("ferr_frame");
    check_busy("ferr_busy");

    for (int it = 0; it < 5; it++) begin
      kind = $urandom_range(0, 2);
      ns   = $urandom_range(0, 2);
      ch   = $urandom_range(0, DC - 1);
      for (int s = 0; s < ns; s++) send_byte(8'($urandom_range(0, 255)), 1'b0);
      if (kind == 0) begin
        send_word(~(32'd1 << (ch + 8)));
        for (int i = 0; i < TOT; i++) send_word($urandom);
      end else if (kind == 1) begin
        @(negedge clk); bus.ch_ready = 4'($urandom);
        send_word(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) send_word($urandom);
      end else begin
        k  = $urandom_range(0, TOT - 1);
        kb = $urandom_range(0, 3);
        send_word(~(32'd1 << (ch + 8)));
        for (int i = 0; i < k; i++) send_word($urandom);
        for (int i = 0; i < kb; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      @(negedge clk); bus.ch_ready = '1;
      model_wait(bus.ch_ready);
      check_writes("rand_wr");
      check_launch("rand_launch");
      check_busy("rand_busy");
      @(negedge clk); bus.ch_ready = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
